gray_to_binary_serial: RTL and testbench
========================================

Name: gray_to_binary_serial

Overview:
- Sequential Gray-to-binary decoder: the decode side of the team's combinational binary-to-Gray encoder.
- Accepts one WIDTH-bit Gray word over a valid/ready handshake and resolves it MSB-first, one bit per clock, using the XOR chain.
- Presents the binary result over a valid/ready output handshake and keeps a wrapping count of delivered words.
- Used where Gray-coded values (e.g. pointers, position codes) must be converted back to binary without a long combinational XOR path.

Parameters:
- WIDTH, 4, data width of the Gray input and binary output; must be >= 2.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  in_data holds a Gray word to decode.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  Gray-coded input word.
- out_valid  output  1  out_data holds a completed decode; high only in HOLD.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  decoded binary word.
- busy  output  1  high in DECODE or HOLD.
- word_cnt  output  CNT_W  number of words delivered, modulo 2^CNT_W.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_data = 0, word_cnt = 0.
  - Internal gray/accumulator/index registers cleared.
  - Any word in flight is discarded; its out_valid is never asserted.
- FSM states: IDLE, DECODE, HOLD.
- IDLE:
  - Input handshake occurs on a rising edge where in_valid && in_ready.
  - On handshake: latch in_data into gray_reg, set idx = WIDTH-1, prev = 0, go to DECODE.
  - in_data is ignored whenever in_ready = 0.
- DECODE: each cycle
  - acc[idx] = prev ^ gray_reg[idx]; prev <= that bit; idx decrements.
  - The edge that processes idx = 0 loads out_data with the full result and moves to HOLD.
  - Occupies exactly WIDTH clock edges.
- Latency:
  - Accept at edge k; out_valid is high after edge k+WIDTH.
  - Example: WIDTH = 4, accept at edge 0, out_valid high after edge 4.
- HOLD:
  - out_valid = 1; out_data and out_valid stay stable until out_ready.
  - On out_valid && out_ready: go to IDLE and word_cnt <= word_cnt + 1, wrapping to 0 after 2^CNT_W - 1.
- No overlap: a new word can be accepted no earlier than the edge after the output handshake. Minimum spacing between accepts is WIDTH+2 cycles.
- out_data changes only on the DECODE->HOLD edge or on reset. It holds the last decoded value through IDLE and DECODE.
- in_valid asserted during DECODE or HOLD has no effect; the word stays pending upstream.
- out_ready asserted outside HOLD has no effect.
- Arithmetic:
  - bin[WIDTH-1] = g[WIDTH-1]
  - bin[i] = bin[i+1] ^ g[i]
  - All values unsigned; no saturation.
- Outputs are registered or decoded from the state register only; there is no combinational path from in_* to out_*.

Test Plan:
1. Reset: hold rst high mid-simulation with random inputs -> in_ready = 1, out_valid = 0, busy = 0, out_data = 0, word_cnt = 0, all immediately (asynchronous).
2. Single decode, WIDTH = 4, out_ready = 1: in_data = 4'b1101 accepted at edge 0 -> out_valid high after edge 4, out_data = 4'b1001, word_cnt = 1 after edge 5, in_ready = 1 after edge 5.
3. Stream, out_ready = 1, in_valid held with 1101, 0010, 1000, 0111 -> out_data sequence 1001, 0011, 1111, 0101; accepts spaced 6 cycles apart; word_cnt = 4.
4. Backpressure: in_data = 4'b1000, out_ready = 0 for 10 cycles after out_valid -> out_valid = 1 and out_data = 4'b1111 stable, in_ready = 0, busy = 1. Raise out_ready -> IDLE on the next edge, word_cnt increments by exactly 1.
5. Reset mid-decode: accept 4'b0111, assert rst after 2 DECODE edges -> outputs return to reset values at once; out_valid never pulses for that word. After release, decoding 4'b0010 yields 4'b0011.
6. Counter wrap and ignored input, CNT_W = 2:
   - Toggle in_valid with junk data during DECODE/HOLD -> junk is never accepted.
   - Deliver 5 words -> word_cnt = 1.

Source files
------------

// File: rtl/gray_to_binary_serial.sv
`timescale 1ns/1ps
// gray_to_binary_serial
//
// Serial Gray-to-binary decoder. It accepts one WIDTH-bit Gray word and
// resolves it MSB-first, one bit per clock, with the running XOR chain
// (bin[MSB] = g[MSB], bin[i] = bin[i+1] ^ g[i]). This avoids a WIDTH-deep
// combinational XOR path. The decoded word is held until it is accepted
// downstream, and a wrapping counter tracks the number of delivered words.
//
// Handshake semantics, on both sides: a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds valid and data
// stable until that edge. ready never depends combinationally on valid:
// in_ready and out_valid are decoded only from the state register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data holds a Gray word
//   in_ready   block can accept a word (IDLE only)
//   in_data    Gray-coded input word [WIDTH-1:0]
//   out_valid  out_data holds a completed decode (HOLD only)
//   out_ready  downstream accepts out_data
//   out_data   decoded binary word [WIDTH-1:0], registered
//   busy       high in DECODE or HOLD
//   word_cnt   delivered words modulo 2^CNT_W [CNT_W-1:0]
module gray_to_binary_serial #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   gray_q, gray_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               prev_q, prev_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               bit_cur;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gray_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      prev_q     <= 1'b0;
      out_data_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gray_q     <= gray_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      out_data_q <= out_data_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    gray_d     = gray_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    prev_d     = prev_q;
    out_data_d = out_data_q;
    word_cnt_d = word_cnt_q;
    bit_cur    = 1'b0;

    case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
        if (in_valid) begin
          gray_d  = in_data;
          idx_d   = IDX_W'(WIDTH - 1);
          prev_d  = 1'b0;
          acc_d   = '0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        bit_cur       = prev_q ^ gray_q[idx_q];
        acc_d[idx_q]  = bit_cur;
        prev_d        = bit_cur;
        if (idx_q == '0) begin
          // The last bit is merged here, so out_data receives the complete word
          // on the same edge that enters HOLD.
          out_data_d = acc_d;
          state_d    = HOLD;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_serial.sv
`timescale 1ns/1ps
// Bench for gray_to_binary_serial. Two instances share every input: dut_a
// uses the default counter width (8) and dut_b uses CNT_W = 2, so the wrap
// case runs on the same traffic as the other cases.
module tb_gray_to_binary_serial;

  localparam int WIDTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data  = '0;
  logic             out_ready = 1'b0;

  logic             in_ready_a, out_valid_a, busy_a;
  logic [WIDTH-1:0] out_data_a;
  logic [7:0]       word_cnt_a;
  logic             in_ready_b, out_valid_b, busy_b;
  logic [WIDTH-1:0] out_data_b;
  logic [1:0]       word_cnt_b;

  gray_to_binary_serial #(.WIDTH(WIDTH), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .busy(busy_a), .word_cnt(word_cnt_a)
  );

  gray_to_binary_serial #(.WIDTH(WIDTH), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .busy(busy_b), .word_cnt(word_cnt_b)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode: bin = g ^ (g>>1) ^ (g>>2) ^ ...
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Output monitor: samples just before the edge that completes the output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst && out_valid_a && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", exp_q.size(), 1);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          check("out_data_a", out_data_a, e);
          check("out_data_b", out_data_b, e);
          check("out_valid_b", out_valid_b, 1);
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic send(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e, output int acc_cyc);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready_a && t < 64) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = -1;
    if (!in_ready_a) begin
      check("accept_timeout", t, 0);
    end else begin
      @(posedge clk);
      acc_cyc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 64) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready_a, 1);
    check({tag, "_out_valid"}, out_valid_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_out_data"}, out_data_a, 0);
    check({tag, "_word_cnt_a"}, word_cnt_a, 0);
    check({tag, "_word_cnt_b"}, word_cnt_b, 0);
    check({tag, "_out_valid_b"}, out_valid_b, 0);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt_a"}, word_cnt_a, 32'(exp_cnt[7:0]));
    check({tag, "_cnt_b"}, word_cnt_b, 32'(exp_cnt[1:0]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ac;
    int acc_c[4];
    logic [WIDTH-1:0] s_in[4];
    logic [WIDTH-1:0] s_out[4];
    int t;

    // Power-on reset.
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // Test 1: random traffic, then asynchronous reset between edges.
    for (int i = 0; i < 30; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = WIDTH'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    exp_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    exp_cnt = 0;

    // Test 2: single decode with latency checks.
    send(4'b1101, 4'b1001, ac);
    in_valid = 1'b0;
    check("t2_busy_e0", busy_a, 1);
    check("t2_in_ready_e0", in_ready_a, 0);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      check("t2_out_valid_decode", out_valid_a, 0);
      check("t2_out_data_held", out_data_a, 0);
    end
    @(negedge clk);
    check("t2_out_valid_e4", out_valid_a, 1);
    check("t2_out_data_e4", out_data_a, 4'b1001);
    @(negedge clk);
    exp_cnt = 1;
    check("t2_in_ready_e5", in_ready_a, 1);
    check("t2_out_valid_e5", out_valid_a, 0);
    check("t2_busy_e5", busy_a, 0);
    check_cnt("t2");

    // Test 3: back-to-back stream with in_valid held high.
    s_in  = '{4'b1101, 4'b0010, 4'b1000, 4'b0111};
    s_out = '{4'b1001, 4'b0011, 4'b1111, 4'b0101};
    for (int i = 0; i < 4; i++) send(s_in[i], s_out[i], acc_c[i]);
    in_valid = 1'b0;
    drain();
    for (int i = 1; i < 4; i++) check("t3_spacing", acc_c[i] - acc_c[i-1], WIDTH + 2);
    exp_cnt = exp_cnt + 4;
    check_cnt("t3");

    // Test 4: backpressure.
    out_ready = 1'b0;
    send(4'b1000, 4'b1111, ac);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t4_reach_hold", out_valid_a, 1);
    for (int i = 0; i < 10; i++) begin
      check("t4_out_valid", out_valid_a, 1);
      check("t4_out_data", out_data_a, 4'b1111);
      check("t4_in_ready", in_ready_a, 0);
      check("t4_busy", busy_a, 1);
      @(negedge clk);
    end
    check_cnt("t4_stalled");
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 1;
    check("t4_in_ready_after", in_ready_a, 1);
    check("t4_out_valid_after", out_valid_a, 0);
    check_cnt("t4");

    // Test 5: reset in the middle of DECODE.
    send(4'b0111, 4'b0101, ac);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_pulse", out_valid_a, 0);
    end
    send(4'b0010, 4'b0011, ac);
    in_valid = 1'b0;
    drain();
    exp_cnt = 1;
    check("t5_out_data_kept", out_data_a, 4'b0011);
    check_cnt("t5");

    // Test 6: junk input while busy, then counter wrap on dut_b.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    out_ready = 1'b0;
    begin
      logic [WIDTH-1:0] g;
      g = WIDTH'($urandom_range(0, 15));
      send(g, g2b(g), ac);
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = WIDTH'($urandom_range(0, 15));
      check("t6_in_ready_busy", in_ready_a, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    exp_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] g;
      g = WIDTH'($urandom_range(0, 15));
      send(g, g2b(g), ac);
    end
    in_valid = 1'b0;
    drain();
    exp_cnt = exp_cnt + 4;
    check_cnt("t6_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
